dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single external DRAM request interface between two requesters: client 0 is the DMA controller and client 1 is a second DRAM master, such as a future video or sound fetcher.
- Sits between the requesters and the top-level dram_* pins of the core.
- Arbitrates round-robin at transaction granularity: one read or write of 32 bits is in flight at a time.
- Latches address, write data and operation, and returns completion and read data to the granted client only.

Parameters:
- TIMEOUT_CYCLES, 1023: BUSY-state cycle limit before abort. Used only with DRAM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- c0_req_read  in  1  client 0 read request (level)
- c0_req_write  in  1  client 0 write request (level)
- c0_addr  in  24  client 0 word address
- c0_wdata  in  32  client 0 write data
- c0_rdata  out  32  client 0 read data, registered
- c0_done  out  1  client 0 completion pulse
- c0_error  out  1  client 0 timeout pulse
- c1_req_read, c1_req_write, c1_addr, c1_wdata, c1_rdata, c1_done, c1_error: same as client 0, for client 1
- dram_req_read  out  1  to DRAM, level
- dram_req_write  out  1  to DRAM, level
- dram_addr  out  24  to DRAM
- dram_data_out  out  32  to DRAM, write data
- dram_data_in  in  32  from DRAM, read data
- dram_data_valid  in  1  DRAM read completion pulse
- dram_write_complete  in  1  DRAM write completion pulse
- grant  out  1  index of the client owning the current or last transaction
- busy  out  1  high in BUSY and DONE

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state=IDLE, last_grant=1, so client 0 wins first.
  - All outputs are 0: dram_req_*, dram_addr, dram_data_out, cX_rdata, cX_done, cX_error, grant, busy.
  - A reset mid-transaction abandons it immediately: dram_req drops the next cycle and no done pulse is issued.
- Client protocol:
  - The client asserts req_read or req_write and holds addr and wdata stable until it sees its done or error pulse.
  - The client deasserts req no later than the cycle after that pulse.
  - If req_read and req_write are both high, the request is treated as a read.
- IDLE:
  - If any request is pending, select the winner: the only requester, or if both request, the client != last_grant.
  - On that edge, register grant, last_grant, dram_addr, dram_data_out and the op; assert the matching dram_req_*; go to BUSY.
  - Latency: request sampled at edge N, dram_req high from N+1.
- BUSY:
  - dram_req_* is held and the other client is ignored.
  - For a read, wait for dram_data_valid. For a write, wait for dram_write_complete. The pulse of the other type is ignored.
  - On the completing edge, clear dram_req_*. For a read, capture dram_data_in into c[grant]_rdata. Go to DONE.
- DONE (exactly one cycle):
  - c[grant]_done=1.
  - The next state is IDLE, and a new grant can be made on the IDLE edge.
  - Minimum back-to-back spacing: 3 cycles per transaction plus the DRAM latency.
- cX_rdata holds its value until that client's next read completes. A write completion leaves it unchanged.
- cX_done and cX_error are single-cycle pulses, never asserted for the non-granted client.
- A DRAM completion pulse that arrives in IDLE or DONE is ignored.

Optional Feature:
- Macro: DRAM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without a completion, clear dram_req_* and go to DONE.
  - In DONE, pulse c[grant]_error=1 with c[grant]_done=0, and leave rdata unchanged.
  - A completion arriving on the same edge as expiry wins: normal done, no error.
- Not defined: no counter is built, cX_error is tied to 0, and BUSY waits indefinitely.

Test Plan:
- Client 0 read only, addr=0x000123, DRAM valid 4 cycles after req with data 0xDEADBEEF -> dram_addr=0x000123, dram_req_read high 4 cycles, c0_rdata=0xDEADBEEF, c0_done one pulse, c1_done stays 0.
- Both clients request writes in the same cycle, after reset -> client 0 is served first (grant=0), then client 1. Repeat with both held continuously: grants alternate 0,1,0,1.
- Client 1 asserts req_read and req_write together, addr=0x00FFFF -> only dram_req_read is asserted; dram_write_complete is ignored; completion comes on data_valid.
- Client 0 write in BUSY, inject dram_data_valid -> ignored, no done. Then dram_write_complete -> c0_done pulse; c0_rdata unchanged from its prior value.
- rst_n low for 1 cycle during BUSY -> next cycle all outputs 0, state IDLE; a later DRAM pulse produces no done.
- With DRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: no DRAM response -> dram_req drops after 8 BUSY cycles, c0_error pulses, c0_done stays 0. Without the macro: still waiting after 100 cycles.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-client round-robin arbiter for the single external DRAM
// request port. One 32-bit read or write is in flight at a time. The selected
// client's address, write data and operation are latched at grant time.
// Completion and read data go back only to the client that owns the transaction.
// Optional feature macro: DRAM_ARB_TIMEOUT_EN. When it is defined, a BUSY-state
// watchdog aborts the transaction after TIMEOUT_CYCLES cycles and pulses cX_error.
module dram_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c0_req_read,
   input  logic        c0_req_write,
   input  logic [23:0] c0_addr,
   input  logic [31:0] c0_wdata,
   output logic [31:0] c0_rdata,
   output logic        c0_done,
   output logic        c0_error,
   input  logic        c1_req_read,
   input  logic        c1_req_write,
   input  logic [23:0] c1_addr,
   input  logic [31:0] c1_wdata,
   output logic [31:0] c1_rdata,
   output logic        c1_done,
   output logic        c1_error,
   output logic        dram_req_read,
   output logic        dram_req_write,
   output logic [23:0] dram_addr,
   output logic [31:0] dram_data_out,
   input  logic [31:0] dram_data_in,
   input  logic        dram_data_valid,
   input  logic        dram_write_complete,
   output logic        grant,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic        last_grant_reg;
   logic        grant_reg;
   logic        op_read_reg;
   logic        dram_req_read_reg;
   logic        dram_req_write_reg;
   logic [23:0] dram_addr_reg;
   logic [31:0] dram_data_out_reg;

   logic        req0, req1;
   logic        win;
   logic        sel_read;
   logic [23:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        launch;
   logic        complete;
   logic        expire;

`ifdef DRAM_ARB_TIMEOUT_EN
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TIMER_W-1:0] timer_reg;
`else
   logic [31:0] timeout_unused;
   assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

   // Winner selection: the sole requester, or the client that did not win last
   // time. A read request takes priority over a simultaneous write request.
   always_comb begin
      req0      = c0_req_read | c0_req_write;
      req1      = c1_req_read | c1_req_write;
      win       = (req0 && req1) ? ~last_grant_reg : req1;
      sel_read  = win ? c1_req_read : c0_req_read;
      sel_addr  = win ? c1_addr : c0_addr;
      sel_wdata = win ? c1_wdata : c0_wdata;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: grant in IDLE, wait for the matching completion in BUSY,
   // and spend exactly one cycle in DONE.
   always_comb begin
      state_next = state_reg;
      launch     = 1'b0;
      complete   = 1'b0;
      expire     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req0 || req1) begin
               launch     = 1'b1;
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            complete = op_read_reg ? dram_data_valid : dram_write_complete;
            if (complete) begin
               state_next = ST_DONE;
            end
`ifdef DRAM_ARB_TIMEOUT_EN
            else if (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
               expire     = 1'b1;
               state_next = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Latch the granted request and drive the DRAM request levels.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_reg     <= 1'b1;
         grant_reg          <= 1'b0;
         op_read_reg        <= 1'b0;
         dram_req_read_reg  <= 1'b0;
         dram_req_write_reg <= 1'b0;
         dram_addr_reg      <= '0;
         dram_data_out_reg  <= '0;
      end else if (launch) begin
         last_grant_reg     <= win;
         grant_reg          <= win;
         op_read_reg        <= sel_read;
         dram_req_read_reg  <= sel_read;
         dram_req_write_reg <= ~sel_read;
         dram_addr_reg      <= sel_addr;
         dram_data_out_reg  <= sel_wdata;
      end else if (complete || expire) begin
         dram_req_read_reg  <= 1'b0;
         dram_req_write_reg <= 1'b0;
      end
   end

`ifdef DRAM_ARB_TIMEOUT_EN
   // BUSY watchdog: cleared on the grant edge, counts every BUSY cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_reg <= '0;
      end else if (launch) begin
         timer_reg <= '0;
      end else if (state_reg == ST_BUSY) begin
         timer_reg <= timer_reg + 1'b1;
      end
   end
`endif

   // Per-client response registers: read data, done pulse and error pulse.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_client
         logic [31:0] rdata_reg;
         logic        done_reg;
         logic        error_reg;
         logic        owner;

         assign owner = (grant_reg == 1'(gi));

         // Completion pulse and read-data capture for the owning client only.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rdata_reg <= '0;
               done_reg  <= 1'b0;
            end else begin
               done_reg <= complete && owner;
               if (complete && op_read_reg && owner) begin
                  rdata_reg <= dram_data_in;
               end
            end
         end

`ifdef DRAM_ARB_TIMEOUT_EN
         // Timeout pulse for the owning client; rdata is left untouched.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               error_reg <= 1'b0;
            end else begin
               error_reg <= expire && owner;
            end
         end
`else
         assign error_reg = 1'b0;
`endif
      end
   endgenerate

   assign c0_rdata       = g_client[0].rdata_reg;
   assign c0_done        = g_client[0].done_reg;
   assign c0_error       = g_client[0].error_reg;
   assign c1_rdata       = g_client[1].rdata_reg;
   assign c1_done        = g_client[1].done_reg;
   assign c1_error       = g_client[1].error_reg;
   assign dram_req_read  = dram_req_read_reg;
   assign dram_req_write = dram_req_write_reg;
   assign dram_addr      = dram_addr_reg;
   assign dram_data_out  = dram_data_out_reg;
   assign grant          = grant_reg;
   assign busy           = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Testbench for dram_arbiter. The stimulus pushes expected completions into a
// queue. A negedge monitor pops an entry on every done/error pulse and compares
// it, and it also checks the DRAM request fields when a request rises.
// A small DRAM responder answers automatically after a set latency, or it sends
// single pulses when the stimulus asks for them.
module tb_dram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c0_req_read, c0_req_write, c1_req_read, c1_req_write;
   logic [23:0] c0_addr, c1_addr;
   logic [31:0] c0_wdata, c1_wdata;
   logic [31:0] c0_rdata, c1_rdata;
   logic        c0_done, c0_error, c1_done, c1_error;
   logic        dram_req_read, dram_req_write;
   logic [23:0] dram_addr;
   logic [31:0] dram_data_out, dram_data_in;
   logic        dram_data_valid, dram_write_complete;
   logic        grant, busy;

   always #5 clk = ~clk;

   dram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .c0_req_read(c0_req_read), .c0_req_write(c0_req_write),
      .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_rdata(c0_rdata),
      .c0_done(c0_done), .c0_error(c0_error),
      .c1_req_read(c1_req_read), .c1_req_write(c1_req_write),
      .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_rdata(c1_rdata),
      .c1_done(c1_done), .c1_error(c1_error),
      .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
      .dram_addr(dram_addr), .dram_data_out(dram_data_out),
      .dram_data_in(dram_data_in), .dram_data_valid(dram_data_valid),
      .dram_write_complete(dram_write_complete),
      .grant(grant), .busy(busy)
   );

   typedef struct {
      bit          client;
      bit          err;
      logic [23:0] addr;
      bit          rd;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_rdata [2];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          req_hi_total = 0;

   // Responder controls, written only by the stimulus process.
   bit          auto_dram = 1'b0;
   int          dram_lat  = 2;
   logic [31:0] dram_rd_data = 32'h0;
   int          inj_kind = 0;
   int          inj_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic inject(input int kind);
      @(negedge clk);
      inj_kind = kind;
      inj_cnt++;
      cyc(1);
   endtask

   task automatic wait_size(input string tag, input int sz);
      int k = 0;
      while (exp_q.size() > sz && k < 300) begin
         @(negedge clk);
         #2;
         k++;
      end
      chk(tag, 32'(exp_q.size()), 32'(sz));
   endtask

   task automatic check_zero(input string p);
      chk({p, "_req_read"}, 32'(dram_req_read), 32'h0);
      chk({p, "_req_write"}, 32'(dram_req_write), 32'h0);
      chk({p, "_addr"}, 32'(dram_addr), 32'h0);
      chk({p, "_data_out"}, dram_data_out, 32'h0);
      chk({p, "_c0_rdata"}, c0_rdata, 32'h0);
      chk({p, "_c1_rdata"}, c1_rdata, 32'h0);
      chk({p, "_pulses"}, {28'h0, c0_done, c1_done, c0_error, c1_error}, 32'h0);
      chk({p, "_grant"}, 32'(grant), 32'h0);
      chk({p, "_busy"}, 32'(busy), 32'h0);
   endtask

   function automatic exp_t mk(input bit c, input bit e, input logic [23:0] a,
                               input bit rd, input logic [31:0] wd, input logic [31:0] rdv);
      exp_t x;
      x.client = c; x.err = e; x.addr = a; x.rd = rd; x.wdata = wd; x.rdata = rdv;
      return x;
   endfunction

   // DRAM responder: automatic replies after dram_lat request cycles, or
   // one-cycle pulses requested by the stimulus (1 = data_valid, 2 = write_complete).
   initial begin
      int cnt  = 0;
      int seen = 0;
      dram_data_valid     = 1'b0;
      dram_write_complete = 1'b0;
      dram_data_in        = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         dram_data_valid     = 1'b0;
         dram_write_complete = 1'b0;
         dram_data_in        = dram_rd_data;
         if (inj_cnt != seen) begin
            seen = inj_cnt;
            if (inj_kind == 1) dram_data_valid = 1'b1;
            else dram_write_complete = 1'b1;
         end else if (auto_dram && (dram_req_read || dram_req_write)) begin
            cnt++;
            if (cnt == dram_lat) begin
               if (dram_req_read) dram_data_valid = 1'b1;
               else dram_write_complete = 1'b1;
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Monitor: scoreboard comparison on every response pulse, request-field check
   // on every rising DRAM request.
   initial begin
      bit   prev_req = 1'b0;
      bit   cur_req;
      exp_t e;
      forever begin
         @(negedge clk);
         cur_req = dram_req_read | dram_req_write;
         if (cur_req) req_hi_total++;
         if (cur_req && !prev_req && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("req_addr", 32'(dram_addr), 32'(e.addr));
            chk("req_op", {30'h0, dram_req_read, dram_req_write}, {30'h0, e.rd, !e.rd});
            if (!e.rd) chk("req_wdata", dram_data_out, e.wdata);
         end
         prev_req = cur_req;
         if (c0_done | c1_done | c0_error | c1_error) begin
            chk("one_client", 32'((c0_done | c0_error) & (c1_done | c1_error)), 32'h0);
            if (exp_q.size() == 0) begin
               chk("spurious_pulse", {28'h0, c0_done, c1_done, c0_error, c1_error}, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_client", 32'(c1_done | c1_error), 32'(e.client));
               chk("resp_grant", 32'(grant), 32'(e.client));
               chk("resp_error", 32'(c0_error | c1_error), 32'(e.err));
               chk("resp_done", 32'(c0_done | c1_done), 32'(!e.err));
               chk("resp_rdata", e.client ? c1_rdata : c0_rdata, e.rdata);
               $display("txn client=%0d err=%0d addr=%06h rd=%0d c0_rdata=%08h c1_rdata=%08h",
                        e.client, e.err, e.addr, e.rd, c0_rdata, c1_rdata);
            end
         end
      end
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      int snap;
      rst_n = 1'b0;
      c0_req_read = 0; c0_req_write = 0; c1_req_read = 0; c1_req_write = 0;
      c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
      exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
      cyc(3);
      check_zero("reset");
      rst_n = 1'b1;
      cyc(2);

      // Both clients write in the same cycle: client 0 first, then client 1.
      auto_dram = 1'b1; dram_lat = 2;
      c0_addr = 24'h000010; c0_wdata = 32'h11111111; c0_req_write = 1;
      c1_addr = 24'h000020; c1_wdata = 32'h22222222; c1_req_write = 1;
      exp_q.push_back(mk(0, 0, 24'h000010, 0, 32'h11111111, exp_rdata[0]));
      exp_q.push_back(mk(1, 0, 24'h000020, 0, 32'h22222222, exp_rdata[1]));
      wait_size("both_first", 1);
      c0_req_write = 0;
      wait_size("both_second", 0);
      c1_req_write = 0;
      cyc(2);

      // Both held continuously: grants alternate 0,1,0,1.
      c0_req_write = 1; c1_req_write = 1;
      exp_q.push_back(mk(0, 0, 24'h000010, 0, 32'h11111111, exp_rdata[0]));
      exp_q.push_back(mk(1, 0, 24'h000020, 0, 32'h22222222, exp_rdata[1]));
      exp_q.push_back(mk(0, 0, 24'h000010, 0, 32'h11111111, exp_rdata[0]));
      exp_q.push_back(mk(1, 0, 24'h000020, 0, 32'h22222222, exp_rdata[1]));
      wait_size("alternate", 0);
      c0_req_write = 0; c1_req_write = 0;
      cyc(2);

      // Client 0 read, DRAM answers after 4 request cycles.
      dram_lat = 4; dram_rd_data = 32'hDEADBEEF;
      snap = req_hi_total;
      c0_addr = 24'h000123; c0_req_read = 1;
      exp_rdata[0] = 32'hDEADBEEF;
      exp_q.push_back(mk(0, 0, 24'h000123, 1, 32'h0, 32'hDEADBEEF));
      wait_size("c0_read", 0);
      c0_req_read = 0;
      chk("c0_read_req_cycles", 32'(req_hi_total - snap), 32'd4);
      cyc(2);

      // Client 1 read+write together: treated as a read, write_complete ignored.
      auto_dram = 1'b0; dram_rd_data = 32'h12345678;
      c1_addr = 24'h00FFFF; c1_wdata = 32'h55AA55AA; c1_req_read = 1; c1_req_write = 1;
      exp_rdata[1] = 32'h12345678;
      exp_q.push_back(mk(1, 0, 24'h00FFFF, 1, 32'h0, 32'h12345678));
      cyc(2);
      inject(2);
      cyc(3);
      chk("rw_ignore_wc_busy", 32'(busy), 32'h1);
      chk("rw_ignore_wc_req", 32'(dram_req_read), 32'h1);
      inject(1);
      wait_size("rw_as_read", 0);
      c1_req_read = 0; c1_req_write = 0;
      cyc(2);

      // Client 0 write: data_valid ignored, write_complete finishes, rdata kept.
      dram_rd_data = 32'h0BADF00D;
      c0_addr = 24'h000456; c0_wdata = 32'hCAFEF00D; c0_req_write = 1;
      exp_q.push_back(mk(0, 0, 24'h000456, 0, 32'hCAFEF00D, exp_rdata[0]));
      cyc(2);
      inject(1);
      cyc(3);
      chk("wr_ignore_valid_busy", 32'(busy), 32'h1);
      chk("wr_ignore_valid_req", 32'(dram_req_write), 32'h1);
      inject(2);
      wait_size("wr_done", 0);
      c0_req_write = 0;
      cyc(1);
      chk("wr_keeps_rdata", c0_rdata, 32'hDEADBEEF);
      cyc(1);

      // Reset during BUSY: everything clears, a late DRAM pulse is ignored.
      c1_addr = 24'h000077; c1_req_read = 1;
      cyc(3);
      chk("pre_reset_busy", 32'(busy), 32'h1);
      rst_n = 1'b0; c1_req_read = 0;
      cyc(1);
      rst_n = 1'b1;
      check_zero("midreset");
      exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
      inject(1);
      cyc(4);
      chk("post_reset_idle", {30'h0, busy, dram_req_read}, 32'h0);

      // No DRAM response at all.
      c0_addr = 24'h000009; c0_wdata = 32'h00000001; c0_req_write = 1;
`ifdef DRAM_ARB_TIMEOUT_EN
      snap = req_hi_total;
      exp_q.push_back(mk(0, 1, 24'h000009, 0, 32'h00000001, exp_rdata[0]));
      wait_size("timeout", 0);
      c0_req_write = 0;
      chk("timeout_req_cycles", 32'(req_hi_total - snap), 32'd8);
      cyc(1);
      chk("timeout_rdata", c0_rdata, exp_rdata[0]);
`else
      exp_q.push_back(mk(0, 0, 24'h000009, 0, 32'h00000001, exp_rdata[0]));
      cyc(100);
      chk("no_timeout_req", 32'(dram_req_write), 32'h1);
      chk("no_timeout_busy", 32'(busy), 32'h1);
      chk("no_timeout_err", {30'h0, c0_error, c0_done}, 32'h0);
      inject(2);
      wait_size("late_done", 0);
      c0_req_write = 0;
`endif
      cyc(3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
